// File: rtl/demux_1to3_buffered_if.sv
// Handshake bundle for demux_1to3_buffered.
// One producer side (selector, in_valid, in_ready, data_in) and three consumer channels
// (outN_valid, outN_ready, dataN), plus the sticky drop_err flag.
// master: the environment (producer and consumers). slave: the demux itself.
interface demux_1to3_buffered_if #(
  parameter int unsigned NBits = 32
);
  logic [1:0]       selector;
  logic             in_valid;
  logic             in_ready;
  logic [NBits-1:0] data_in;

  logic             out0_valid;
  logic             out1_valid;
  logic             out2_valid;
  logic             out0_ready;
  logic             out1_ready;
  logic             out2_ready;
  logic [NBits-1:0] data0;
  logic [NBits-1:0] data1;
  logic [NBits-1:0] data2;

  logic             drop_err;

  modport master (
    output selector, in_valid, data_in, out0_ready, out1_ready, out2_ready,
    input  in_ready, out0_valid, out1_valid, out2_valid, data0, data1, data2, drop_err
  );

  modport slave (
    input  selector, in_valid, data_in, out0_ready, out1_ready, out2_ready,
    output in_ready, out0_valid, out1_valid, out2_valid, data0, data1, data2, drop_err
  );
endinterface

// File: rtl/demux_1to3_buffered.sv
// 1-to-3 demultiplexer with a one-entry holding register per output channel.
// A producer beat is steered by selector (0..2) into the matching channel register; each
// channel drains independently through its own valid/ready handshake. Selector 2'b11 beats
// are consumed and discarded, setting the sticky drop_err flag.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - demux_1to3_buffered_if slave modport (producer handshake, three channels, drop_err)
module demux_1to3_buffered #(
  parameter int unsigned NBits = 32
) (
  input logic                   clk,
  input logic                   reset,
  demux_1to3_buffered_if.slave  bus
);

  typedef enum logic {StEmpty, StFull} ch_state_e;

  ch_state_e        state_q [3];
  logic [NBits-1:0] data_q  [3];
  logic             drop_err_q;

  logic [2:0] out_ready;
  logic [2:0] drain;
  logic [2:0] accept_ch;
  logic       in_ready;
  logic       accept;

  assign out_ready = {bus.out2_ready, bus.out1_ready, bus.out0_ready};

  always_comb begin
    drain = '0;
    for (int i = 0; i < 3; i++) begin
      drain[i] = (state_q[i] == StFull) && out_ready[i];
    end
  end

  // Only combinational path from a consumer: outN_ready -> in_ready.
  always_comb begin
    in_ready = 1'b1;
    unique case (bus.selector)
      2'b00:   in_ready = (state_q[0] == StEmpty) || drain[0];
      2'b01:   in_ready = (state_q[1] == StEmpty) || drain[1];
      2'b10:   in_ready = (state_q[2] == StEmpty) || drain[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

  always_comb begin
    accept_ch = '0;
    for (int i = 0; i < 3; i++) begin
      accept_ch[i] = accept && (bus.selector == 2'(i));
    end
  end

  // Per-channel FSM. A FULL channel without a drain cannot see an accept (in_ready is low),
  // so it simply holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= StEmpty;
        data_q[i]  <= '0;
      end
      drop_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        unique case (state_q[i])
          StEmpty: begin
            if (accept_ch[i]) begin
              state_q[i] <= StFull;
              data_q[i]  <= bus.data_in;
            end
          end
          StFull: begin
            if (drain[i]) begin
              if (accept_ch[i]) begin
                data_q[i] <= bus.data_in;
              end else begin
                state_q[i] <= StEmpty;
              end
            end
          end
          default: state_q[i] <= StEmpty;
        endcase
      end
      if (accept && (bus.selector == 2'b11)) begin
        drop_err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = (state_q[0] == StFull);
  assign bus.out1_valid = (state_q[1] == StFull);
  assign bus.out2_valid = (state_q[2] == StFull);
  assign bus.data0      = data_q[0];
  assign bus.data1      = data_q[1];
  assign bus.data2      = data_q[2];
  assign bus.drop_err   = drop_err_q;

endmodule

// File: tb/tb_demux_1to3_buffered.sv
// Self-checking bench for demux_1to3_buffered: directed scenarios plus randomized traffic
// checked against an occupancy/last-value model of the three channels.
module tb_demux_1to3_buffered;

  localparam int unsigned NBits = 32;

  logic clk;
  logic reset;

  demux_1to3_buffered_if #(.NBits(NBits)) bus ();

  demux_1to3_buffered #(.NBits(NBits)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: each channel holds 0 or 1 beat; shown value is the last beat written.
  int               m_cnt  [3];
  logic [NBits-1:0] m_data [3];
  logic             m_drop;

  function automatic logic dut_valid(int i);
    case (i)
      0:       return bus.out0_valid;
      1:       return bus.out1_valid;
      default: return bus.out2_valid;
    endcase
  endfunction

  function automatic logic [NBits-1:0] dut_data(int i);
    case (i)
      0:       return bus.data0;
      1:       return bus.data1;
      default: return bus.data2;
    endcase
  endfunction

  function automatic logic rdy_of(int i);
    case (i)
      0:       return bus.out0_ready;
      1:       return bus.out1_ready;
      default: return bus.out2_ready;
    endcase
  endfunction

  function automatic logic model_ready();
    int s;
    s = int'(bus.selector);
    if (s == 3) return 1'b1;
    return (m_cnt[s] == 0) || rdy_of(s);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]  = 0;
      m_data[i] = '0;
    end
    m_drop = 1'b0;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    logic acc;
    int   s;
    int   nc [3];
    acc = bus.in_valid && model_ready();
    s   = int'(bus.selector);
    for (int i = 0; i < 3; i++) begin
      nc[i] = m_cnt[i];
      if (m_cnt[i] == 1 && rdy_of(i)) nc[i] = nc[i] - 1;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) m_cnt[i] = nc[i];
    if (acc) begin
      if (s == 3) m_drop = 1'b1;
      else begin
        m_cnt[s]  = m_cnt[s] + 1;
        m_data[s] = bus.data_in;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.selector   = 2'b00;
    bus.data_in    = '0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    bus.out2_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_clear();
    #12;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (dut_valid(i) !== 1'b0 || dut_data(i) !== '0) begin
        n_err++;
        $display("FAIL reset_ch%0d: valid=%b data=%h, want 0/0", i, dut_valid(i), dut_data(i));
      end
    end
    n_cmp++;
    if (bus.drop_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_drop: got %b want 0", bus.drop_err);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_routing();
    bus.selector   = 2'b10;
    bus.data_in    = 32'hDEADBEEF;
    bus.in_valid   = 1'b1;
    bus.out2_ready = 1'b1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL route_inready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out2_valid !== 1'b1 || bus.data2 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL route_ch2: valid=%b data=%h want 1/deadbeef", bus.out2_valid, bus.data2);
    end
    n_cmp++;
    if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
      n_err++;
      $display("FAIL route_others: v0=%b v1=%b want 0/0", bus.out0_valid, bus.out1_valid);
    end
    tick();
    n_cmp++;
    if (bus.out2_valid !== 1'b0 || bus.data2 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL route_drained: valid=%b data=%h want 0/deadbeef", bus.out2_valid,
               bus.data2);
    end
  endtask

  task automatic test_backpressure();
    bus.out1_ready = 1'b0;
    bus.selector   = 2'b01;
    bus.data_in    = 32'h11;
    bus.in_valid   = 1'b1;
    tick();
    bus.data_in = 32'h22;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_stall_inready: got %b want 0", bus.in_ready);
    end
    tick();
    n_cmp++;
    if (bus.out1_valid !== 1'b1 || bus.data1 !== 32'h11) begin
      n_err++;
      $display("FAIL bp_hold: valid=%b data=%h want 1/11", bus.out1_valid, bus.data1);
    end
    bus.out1_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_inready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out1_valid !== 1'b1 || bus.data1 !== 32'h22) begin
      n_err++;
      $display("FAIL bp_second: valid=%b data=%h want 1/22", bus.out1_valid, bus.data1);
    end
    tick();
  endtask

  task automatic test_streaming();
    bus.out0_ready = 1'b1;
    bus.selector   = 2'b00;
    bus.in_valid   = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      bus.data_in = NBits'(v);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL stream_inready beat %0d: got %b want 1", v, bus.in_ready);
      end
      tick();
      n_cmp++;
      if (bus.out0_valid !== 1'b1 || bus.data0 !== NBits'(v)) begin
        n_err++;
        $display("FAIL stream_data beat %0d: valid=%b data=%h want 1/%h", v, bus.out0_valid,
                 bus.data0, NBits'(v));
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_independence();
    bus.out0_ready = 1'b0;
    bus.out2_ready = 1'b0;
    bus.selector   = 2'b00;
    bus.data_in    = 32'hA;
    bus.in_valid   = 1'b1;
    tick();
    bus.selector = 2'b10;
    bus.data_in  = 32'hB;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL indep_inready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out2_valid !== 1'b1 || bus.data2 !== 32'hB) begin
      n_err++;
      $display("FAIL indep_ch2: valid=%b data=%h want 1/b", bus.out2_valid, bus.data2);
    end
    n_cmp++;
    if (bus.out0_valid !== 1'b1 || bus.data0 !== 32'hA) begin
      n_err++;
      $display("FAIL indep_ch0: valid=%b data=%h want 1/a", bus.out0_valid, bus.data0);
    end
    bus.out0_ready = 1'b1;
    bus.out2_ready = 1'b1;
    tick();
  endtask

  task automatic test_invalid_sel();
    bus.selector = 2'b11;
    bus.data_in  = 32'h55;
    bus.in_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL inv_inready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (dut_valid(i) !== 1'b0) begin
        n_err++;
        $display("FAIL inv_ch%0d_valid: got %b want 0", i, dut_valid(i));
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (bus.drop_err !== 1'b1) begin
        n_err++;
        $display("FAIL inv_drop_sticky cycle %0d: got %b want 1", k, bus.drop_err);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.selector   = 2'($urandom_range(0, 3));
      bus.in_valid   = 1'($urandom_range(0, 3) != 0);
      bus.data_in    = $urandom;
      bus.out0_ready = 1'($urandom_range(0, 2) != 0);
      bus.out1_ready = 1'($urandom_range(0, 2) == 0);
      bus.out2_ready = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (bus.in_ready !== model_ready()) begin
        n_err++;
        $display("FAIL rand_inready cycle %0d: got %b want %b", c, bus.in_ready, model_ready());
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (dut_valid(i) !== (m_cnt[i] == 1) || dut_data(i) !== m_data[i]) begin
          n_err++;
          $display("FAIL rand_ch%0d cycle %0d: valid=%b data=%h want %b/%h", i, c,
                   dut_valid(i), dut_data(i), (m_cnt[i] == 1), m_data[i]);
        end
      end
      n_cmp++;
      if (bus.drop_err !== m_drop) begin
        n_err++;
        $display("FAIL rand_drop cycle %0d: got %b want %b", c, bus.drop_err, m_drop);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midrun();
    bus.out1_ready = 1'b0;
    bus.selector   = 2'b01;
    bus.data_in    = 32'h77;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    // Make sure drop_err is set so its clearing is visible.
    bus.selector = 2'b11;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    reset = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (dut_valid(i) !== 1'b0 || dut_data(i) !== '0) begin
        n_err++;
        $display("FAIL midreset_ch%0d: valid=%b data=%h want 0/0", i, dut_valid(i),
                 dut_data(i));
      end
    end
    n_cmp++;
    if (bus.drop_err !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_drop: got %b want 0", bus.drop_err);
    end
    @(negedge clk);
    reset          = 1'b1;
    bus.out1_ready = 1'b1;
    bus.selector   = 2'b01;
    bus.data_in    = 32'h99;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out1_valid !== 1'b1 || bus.data1 !== 32'h99) begin
      n_err++;
      $display("FAIL postreset_first: valid=%b data=%h want 1/99", bus.out1_valid, bus.data1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_routing();
    test_backpressure();
    test_streaming();
    test_independence();
    test_invalid_sel();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
